// File: rtl/pong_rect_fill.sv
// pong_rect_fill: raster rectangle fill into a 128x64 RGB555 framebuffer.
// Optional macro FB_CLIP_EN clips rectangles to the framebuffer edges; otherwise coordinates wrap.
module pong_rect_fill (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic [7:0]  cmd_w,
    input  logic [6:0]  cmd_h,
    input  logic [14:0] cmd_color,
    output logic        busy,
    output logic        done,
    output logic [12:0] mem_waddr,
    output logic [14:0] mem_wdata,
    output logic        mem_web
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [6:0]  x0;
    logic [7:0]  w_r;
    logic [6:0]  h_r;
    logic [7:0]  col;
    logic [6:0]  row;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic [14:0] color;

    logic [7:0]  w_eff;
    logic [6:0]  h_eff;
    logic        empty;
    logic        accept;
    logic        row_end;
    logic        last;

`ifdef FB_CLIP_EN
    logic [7:0] w_room;
    logic [6:0] h_room;

    // Clip the requested size to the space left before the framebuffer edge.
    always_comb begin
        w_room = 8'd128 - {1'b0, cmd_x};
        h_room = 7'd64 - {1'b0, cmd_y};
        w_eff  = (cmd_w < w_room) ? cmd_w : w_room;
        h_eff  = (cmd_h < h_room) ? cmd_h : h_room;
    end
`else
    // Without clipping the requested size is used as-is; addresses wrap.
    always_comb begin
        w_eff = cmd_w;
        h_eff = cmd_h;
    end
`endif

    // Command decode and end-of-row / end-of-rectangle detection.
    always_comb begin
        empty   = (w_eff == 8'd0) || (h_eff == 7'd0);
        accept  = cmd_valid && (state == IDLE);
        row_end = (col == w_r - 8'd1);
        last    = row_end && (row == h_r - 7'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mem_web    = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = empty ? FIN : FILL;
                end
            end
            FILL: begin
                mem_web = 1'b0;
                if (last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch and raster walk; the write address/data registers
    // only move when a pixel is about to be written, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0    <= 7'd0;
            w_r   <= 8'd0;
            h_r   <= 7'd0;
            col   <= 8'd0;
            row   <= 7'd0;
            cur_x <= 7'd0;
            cur_y <= 6'd0;
            color <= 15'd0;
        end else if (accept) begin
            x0  <= cmd_x;
            w_r <= w_eff;
            h_r <= h_eff;
            col <= 8'd0;
            row <= 7'd0;
            if (!empty) begin
                cur_x <= cmd_x;
                cur_y <= cmd_y;
                color <= cmd_color;
            end
        end else if (state == FILL && !last) begin
            if (row_end) begin
                col   <= 8'd0;
                cur_x <= x0;
                row   <= row + 7'd1;
                cur_y <= cur_y + 6'd1;
            end else begin
                col   <= col + 8'd1;
                cur_x <= cur_x + 7'd1;
            end
        end
    end

    assign mem_waddr = {cur_y, cur_x};
    assign mem_wdata = color;

endmodule

// File: tb/tb_pong_rect_fill.sv
// tb_pong_rect_fill: directed self-checking bench for pong_rect_fill.
// Honours FB_CLIP_EN the same way as the design for the clipped-edge case.
module tb_pong_rect_fill;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [14:0] cmd_color;
    logic        busy;
    logic        done;
    logic [12:0] mem_waddr;
    logic [14:0] mem_wdata;
    logic        mem_web;

    int passed = 0;
    int total  = 0;

    int n_wr;
    int done_at;
    int bad_data;
    int addrs[$];

    pong_rect_fill dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_web   (mem_web)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_cmd(input int x, input int y, input int w,
                           input int h, input int c);
        cmd_x     = 7'(x);
        cmd_y     = 6'(y);
        cmd_w     = 8'(w);
        cmd_h     = 7'(h);
        cmd_color = 15'(c);
    endtask

    // Called at the negedge just after the accept edge (cycle 0).
    // Records writes until done, bounded by limit cycles.
    task automatic collect(input int limit, input int c);
        n_wr     = 0;
        done_at  = -1;
        bad_data = 0;
        addrs.delete();
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (mem_web == 1'b0) begin
                n_wr++;
                addrs.push_back(int'(mem_waddr));
                if (int'(mem_wdata) != c) bad_data++;
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(input int x, input int y, input int w,
                         input int h, input int c);
        set_cmd(x, y, w, h, c);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        set_cmd(99, 40, 200, 100, 'h1234);
    endtask

    int exp_a[8] = '{386, 387, 388, 389, 514, 515, 516, 517};
`ifdef FB_CLIP_EN
    int exp_c[2] = '{8190, 8191};
`else
    int exp_c[8] = '{8190, 8191, 8064, 8065, 126, 127, 0, 1};
`endif

    initial begin
        int busy_cnt;
        int order_bad;
        int wr_cnt;

        rst       = 1'b1;
        cmd_valid = 1'b1;
        set_cmd(2, 3, 4, 2, 'h7FFF);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_web", int'(mem_web), 1);
        chk("rst_addr", int'(mem_waddr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);

        // First edge with rst low accepts the held command.
        rst = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        set_cmd(99, 40, 200, 100, 'h1234);
        chk("a_busy", int'(busy), 1);
        chk("a_ready", int'(cmd_ready), 0);
        collect(50, 'h7FFF);
        chk("a_nwr", n_wr, 8);
        chk("a_done_at", done_at, 8);
        chk("a_data", bad_data, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_addr%0d", i),
                (i < addrs.size()) ? addrs[i] : -1, exp_a[i]);
        end
        chk("a_fin_web", int'(mem_web), 1);
        chk("a_fin_hold", int'(mem_waddr), 517);
        @(negedge clk);
        chk("a_idle_done", int'(done), 0);
        chk("a_idle_ready", int'(cmd_ready), 1);
        chk("a_idle_busy", int'(busy), 0);
        chk("a_idle_hold", int'(mem_waddr), 517);
        chk("a_idle_wdata", int'(mem_wdata), 'h7FFF);

        // Zero-width command.
        issue(5, 5, 0, 5, 'h0F0F);
        chk("b_done", int'(done), 1);
        chk("b_web", int'(mem_web), 1);
        chk("b_ready", int'(cmd_ready), 0);
        chk("b_hold", int'(mem_waddr), 517);
        @(negedge clk);
        chk("b_ready2", int'(cmd_ready), 1);
        chk("b_done2", int'(done), 0);

        // Edge of the framebuffer: clip or wrap.
        issue(126, 63, 4, 2, 'h001F);
        collect(50, 'h001F);
`ifdef FB_CLIP_EN
        chk("c_nwr", n_wr, 2);
        chk("c_done_at", done_at, 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("c_addr%0d", i),
                (i < addrs.size()) ? addrs[i] : -1, exp_c[i]);
        end
`else
        chk("c_nwr", n_wr, 8);
        chk("c_done_at", done_at, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("c_addr%0d", i),
                (i < addrs.size()) ? addrs[i] : -1, exp_c[i]);
        end
`endif
        chk("c_data", bad_data, 0);
        @(negedge clk);

        // Reset on the third write cycle of a 10x10 fill.
        issue(0, 10, 10, 10, 'h5555);
        chk("d_w0", int'(mem_web), 0);
        @(negedge clk);
        @(negedge clk);
        chk("d_w2", int'(mem_web), 0);
        chk("d_w2_addr", int'(mem_waddr), 1282);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("d_web", int'(mem_web), 1);
        chk("d_ready", int'(cmd_ready), 1);
        chk("d_busy", int'(busy), 0);
        chk("d_addr", int'(mem_waddr), 0);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_web == 1'b0 || done) wr_cnt++;
            @(negedge clk);
        end
        chk("d_quiet", wr_cnt, 0);

        // Back-to-back with cmd_valid held high.
        set_cmd(10, 1, 3, 2, 'h0A0A);
        cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(20, 1, 2, 1, 'h0B0B);
        wr_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (cmd_ready) wr_cnt++;
            @(negedge clk);
        end
        chk("e_ready_low", wr_cnt, 0);
        chk("e_ready_k7", int'(cmd_ready), 1);
        chk("e_done_k6", int'(done), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("e_accept_k8", int'(mem_web), 0);
        chk("e_addr_k8", int'(mem_waddr), 148);
        chk("e_data_k8", int'(mem_wdata), 'h0B0B);
        @(negedge clk);
        chk("e_addr_k9", int'(mem_waddr), 149);
        @(negedge clk);
        chk("e_done_k10", int'(done), 1);
        @(negedge clk);

        // Full-screen clear.
        issue(0, 0, 128, 64, 'h0000);
        busy_cnt  = 0;
        order_bad = 0;
        wr_cnt    = 0;
        for (int i = 0; i < 9000; i++) begin
            if (!busy) break;
            busy_cnt++;
            if (mem_web == 1'b0) begin
                if (int'(mem_waddr) != wr_cnt) order_bad++;
                wr_cnt++;
            end
            @(negedge clk);
        end
        chk("f_writes", wr_cnt, 8192);
        chk("f_order", order_bad, 0);
        chk("f_busy", busy_cnt, 8193);
        chk("f_ready", int'(cmd_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
